csr_timer_bank: RTL and testbench
=================================

// Module: csr_timer_bank
// PURPOSE
//  Parametrised bank of NUM_TIMERS countdown timers with a 64-bit stable counter, all CSR-mapped.
//  Sits beside the CSR register file in the WB stage and shares its csr_num/we/wmask/wvalue write port.
//  Per-channel interrupt pending bits feed ESTAT.IS[TI]; adds one-shot/periodic mode per channel,
//  write-1-to-clear with set priority, and RDCNT support.
// PARAMETERS
//  NUM_TIMERS  2       number of timer channels, 1..4
//  CNT_W       32      timer counter width, 16..32; INITVAL field = CNT_W-2 bits
//  CSR_NUM_W   14      width of csr_num
//  TIMER_BASE  14'h41  csr_num of channel 0 TCFG; channel i base = TIMER_BASE + 4*i
// PORTS
//  clk          in   1              clock
//  reset        in   1              synchronous, active-high
//  csr_num      in   CSR_NUM_W      CSR address of current read/write
//  csr_we       in   1              write enable, one cycle per write
//  csr_wmask    in   32             bit write mask
//  csr_wvalue   in   32             write data
//  csr_hit      out  1              csr_num decodes to a register in this bank
//  csr_rvalue   out  32             read data, combinational; 0 when !csr_hit
//  tid_in       in   32             reset value of each channel TID
//  irq_pending  out  NUM_TIMERS     per-channel timer interrupt pending
//  timer_int    out  1              OR of irq_pending, drives ESTAT.IS[11]
//  stable_cnt   out  64             free-running counter for RDCNTVL/RDCNTVH
// BEHAVIOUR
//  Register map, channel i, base B = TIMER_BASE + 4*i:
//   B+0 TCFG: [0] EN, [1] PERIODIC, [CNT_W-1:2] INITVAL; bits 31:CNT_W read 0.
//   B+1 TVAL: read-only; returns zero-extended cnt.
//   B+2 TID: RW, 32 bits.
//   B+3 TICLR: write-only; reads 0.
//  Masked write rule: new = wmask & wvalue | ~wmask & old.
//  Reset: EN=0, PERIODIC=0, INITVAL=0, cnt = all-ones, irq_pending=0, TID=tid_in, stable_cnt=0.
//   csr_hit and csr_rvalue then follow csr_num combinationally.
//  TCFG write whose new EN=1: cnt <= {new INITVAL, 2'b00} in the next cycle, replacing any decrement.
//   Re-writing TCFG while the timer runs restarts it.
//  TCFG write whose new EN=0: cnt freezes at its current value.
//  Counting, per cycle, when EN=1 and no TCFG write to that channel:
//   - cnt == all-ones: hold (one-shot expired).
//   - cnt == 0 && PERIODIC: reload {INITVAL, 2'b00}.
//   - otherwise: cnt <= cnt - 1; 0 wraps to all-ones, which stops a one-shot timer.
//  Pending:
//   - Set on the clock edge after a cycle in which EN=1 and cnt == 0; fires once per expiry.
//   - A frozen cnt == 0 with EN=0 does not set pending.
//   - Cleared by a TICLR write with (wmask & wvalue)[0] = 1.
//   - Set and clear in the same cycle: set wins.
//  INITVAL=0, periodic: pending is set every cycle; clearing is ineffective. This is a legal edge case.
//  stable_cnt increments by 1 every cycle and wraps 2^64-1 -> 0. Not writable.
//  Reads and writes to the same register in one cycle: read returns the pre-write value.
//  Writes to unmapped csr_num are ignored; csr_hit=0.
//  timer_int is registered-equivalent: the OR of the irq_pending flops, no combinational input path.
// STRUCTURE
//  Shared package/include (timer_defs.vh):
//   - offsets TIMER_OFF_TCFG=0, TVAL=1, TID=2, TICLR=3
//   - bit fields TCFG_EN=0, TCFG_PERIODIC=1, TICLR_CLR=0
//   - channel stride 4
//  Sub-module csr_timer_chan: one channel (TCFG, TID, cnt, pending, local decode).
//   Instantiated NUM_TIMERS times by generate.
//  Top level: stable counter, rvalue OR-mux, csr_hit OR-reduce.
// TESTING
//  1. Reset, then read 0x41/0x42/0x44
//     -> 0x0 / 0xFFFFFFFF / 0x0; irq_pending=0; stable_cnt=0 and +1 each cycle.
//  2. Write TCFG ch0 = 0x0000_0011 (INITVAL=4, one-shot, EN)
//     -> TVAL reads 16,15,...,0; pending set the next cycle; TVAL then holds 0xFFFFFFFF; no second set.
//  3. Write TCFG ch1 (0x45) = 0x0000_000B (INITVAL=2, periodic)
//     -> pending every 9 cycles (8,...,0, reload); TICLR 0x48 wvalue=1 clears it until the next expiry.
//  4. TICLR write in the exact cycle cnt==0
//     -> pending remains 1 (set wins); a TICLR write with wmask=0 leaves pending set.
//  5. TCFG write EN=0 mid-count at TVAL=5
//     -> TVAL frozen at 5 for 20 cycles, no pending.
//     Then write EN=1 with INITVAL=1 -> TVAL=4 next cycle.
//  6. Assert reset while ch0 periodic is running with pending=1
//     -> next cycle all state equals reset values; TID reads tid_in (e.g. 0x0000_0003).

Source files
------------

// File: rtl/csr_timer_bank_pkg.sv
// Shared definitions for the CSR timer bank: register offsets, field positions and write helpers.
package csr_timer_bank_pkg;

    localparam logic [1:0] TIMER_OFF_TCFG  = 2'd0;
    localparam logic [1:0] TIMER_OFF_TVAL  = 2'd1;
    localparam logic [1:0] TIMER_OFF_TID   = 2'd2;
    localparam logic [1:0] TIMER_OFF_TICLR = 2'd3;

    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;
    localparam int TICLR_CLR     = 0;
    localparam int CHAN_STRIDE   = 4;

    function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                                 input logic [31:0] wmask,
                                                 input logic [31:0] wvalue);
        return (wmask & wvalue) | (~wmask & old_val);
    endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// One countdown timer channel: TCFG/TID/TVAL/TICLR registers, counter and pending flag.
module csr_timer_chan
    import csr_timer_bank_pkg::*;
#(
    parameter int                   CNT_W     = 32,
    parameter int                   CSR_NUM_W = 14,
    parameter logic [CSR_NUM_W-1:0] BASE      = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CSR_NUM_W-1:0] csr_num,
    input  logic                 csr_we,
    input  logic [31:0]          csr_wmask,
    input  logic [31:0]          csr_wvalue,
    input  logic [31:0]          tid_in,
    output logic                 hit,
    output logic [31:0]          rvalue,
    output logic                 irq_pending
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                 en;
    logic                 periodic;
    logic [CNT_W-3:0]     initval;
    logic [CNT_W-1:0]     cnt;
    logic [31:0]          tid;
    logic [CSR_NUM_W-1:0] off;
    logic [1:0]           regsel;
    logic [CNT_W-1:0]     tcfg_cur;
    logic [CNT_W-1:0]     tcfg_new;
    logic                 tcfg_wr;
    logic                 tid_wr;
    logic                 clr_wr;
    logic                 expire;

    // Unsigned wrap makes csr_num below BASE land far outside the 4-register window.
    assign off    = csr_num - BASE;
    assign hit    = (off[CSR_NUM_W-1:2] == '0);
    assign regsel = off[1:0];

    assign tcfg_cur = {initval, periodic, en};
    assign tcfg_new = (csr_wmask[CNT_W-1:0] & csr_wvalue[CNT_W-1:0])
                    | (~csr_wmask[CNT_W-1:0] & tcfg_cur);

    assign tcfg_wr = csr_we && hit && (regsel == TIMER_OFF_TCFG);
    assign tid_wr  = csr_we && hit && (regsel == TIMER_OFF_TID);
    assign clr_wr  = csr_we && hit && (regsel == TIMER_OFF_TICLR)
                   && csr_wmask[TICLR_CLR] && csr_wvalue[TICLR_CLR];
    assign expire  = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            en          <= 1'b0;
            periodic    <= 1'b0;
            initval     <= '0;
            cnt         <= '1;
            tid         <= tid_in;
            irq_pending <= 1'b0;
        end else begin
            if (tcfg_wr) begin
                en       <= tcfg_new[TCFG_EN];
                periodic <= tcfg_new[TCFG_PERIODIC];
                initval  <= tcfg_new[CNT_W-1:2];
            end
            if (tid_wr) begin
                tid <= masked_write(tid, csr_wmask, csr_wvalue);
            end
            // A TCFG write always takes precedence over counting; EN=0 simply freezes cnt.
            if (tcfg_wr) begin
                if (tcfg_new[TCFG_EN]) begin
                    cnt <= {tcfg_new[CNT_W-1:2], 2'b00};
                end
            end else if (en && (cnt != '1)) begin
                if ((cnt == '0) && periodic) begin
                    cnt <= {initval, 2'b00};
                end else begin
                    cnt <= cnt - CNT_ONE;
                end
            end
            if (expire) begin
                irq_pending <= 1'b1;
            end else if (clr_wr) begin
                irq_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        rvalue = '0;
        if (hit) begin
            case (regsel)
                TIMER_OFF_TCFG: rvalue = 32'(tcfg_cur);
                TIMER_OFF_TVAL: rvalue = 32'(cnt);
                TIMER_OFF_TID:  rvalue = tid;
                default:        rvalue = '0;
            endcase
        end
    end

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of CSR-mapped countdown timers plus a 64-bit free-running stable counter.
module csr_timer_bank
    import csr_timer_bank_pkg::*;
#(
    parameter int                   NUM_TIMERS = 2,
    parameter int                   CNT_W      = 32,
    parameter int                   CSR_NUM_W  = 14,
    parameter logic [CSR_NUM_W-1:0] TIMER_BASE = 14'h41
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CSR_NUM_W-1:0]  csr_num,
    input  logic                  csr_we,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wvalue,
    output logic                  csr_hit,
    output logic [31:0]           csr_rvalue,
    input  logic [31:0]           tid_in,
    output logic [NUM_TIMERS-1:0] irq_pending,
    output logic                  timer_int,
    output logic [63:0]           stable_cnt
);

    logic [NUM_TIMERS-1:0] chan_hit;
    logic [31:0]           chan_rvalue [NUM_TIMERS];

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 64'd1;
        end
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
        csr_timer_chan #(
            .CNT_W     (CNT_W),
            .CSR_NUM_W (CSR_NUM_W),
            .BASE      (CSR_NUM_W'(TIMER_BASE + CHAN_STRIDE * i))
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .csr_num     (csr_num),
            .csr_we      (csr_we),
            .csr_wmask   (csr_wmask),
            .csr_wvalue  (csr_wvalue),
            .tid_in      (tid_in),
            .hit         (chan_hit[i]),
            .rvalue      (chan_rvalue[i]),
            .irq_pending (irq_pending[i])
        );
    end

    // Channel windows are disjoint and non-hit channels drive zero, so OR acts as the mux.
    always_comb begin
        csr_rvalue = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            csr_rvalue = csr_rvalue | chan_rvalue[i];
        end
    end

    assign csr_hit   = |chan_hit;
    assign timer_int = |irq_pending;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank: register map, one-shot/periodic counting, pending set/clear, reset.
module tb_csr_timer_bank;

    logic        clk;
    logic        reset;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        csr_hit;
    logic [31:0] csr_rvalue;
    logic [31:0] tid_in;
    logic [1:0]  irq_pending;
    logic        timer_int;
    logic [63:0] stable_cnt;

    int checks = 0;
    int errors = 0;

    csr_timer_bank dut (
        .clk         (clk),
        .reset       (reset),
        .csr_num     (csr_num),
        .csr_we      (csr_we),
        .csr_wmask   (csr_wmask),
        .csr_wvalue  (csr_wvalue),
        .csr_hit     (csr_hit),
        .csr_rvalue  (csr_rvalue),
        .tid_in      (tid_in),
        .irq_pending (irq_pending),
        .timer_int   (timer_int),
        .stable_cnt  (stable_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_num    = num;
        csr_wmask  = mask;
        csr_wvalue = val;
        csr_we     = 1'b1;
        tick();
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] num, input logic [31:0] exp);
        csr_num = num;
        #1;
        chk(tag, {32'd0, csr_rvalue}, {32'd0, exp});
    endtask

    initial begin
        reset      = 1'b1;
        csr_num    = '0;
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
        tid_in     = 32'h0000_0003;
        tick();
        tick();

        // Reset state and basic decode
        chk("rst_stable", stable_cnt, 64'd0);
        chk("rst_irq", {62'd0, irq_pending}, 64'd0);
        chk("rst_int", {63'd0, timer_int}, 64'd0);
        reset = 1'b0;
        rd_chk("rst_tcfg0", 14'h41, 32'h0);
        chk("hit_41", {63'd0, csr_hit}, 64'd1);
        rd_chk("rst_tval0", 14'h42, 32'hFFFF_FFFF);
        rd_chk("rst_tid0", 14'h43, 32'h0000_0003);
        rd_chk("rst_ticlr0", 14'h44, 32'h0);
        rd_chk("unmapped_40", 14'h40, 32'h0);
        chk("hit_40", {63'd0, csr_hit}, 64'd0);
        rd_chk("unmapped_49", 14'h49, 32'h0);
        chk("hit_49", {63'd0, csr_hit}, 64'd0);
        tick();
        chk("stable_1", stable_cnt, 64'd1);
        tick();
        chk("stable_2", stable_cnt, 64'd2);

        // Unmapped write ignored; masked TID write with read-before-write
        csr_wr(14'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_chk("tid1_pre", 14'h47, 32'h0000_0003);
        csr_num    = 14'h47;
        csr_wmask  = 32'h0000_FFFF;
        csr_wvalue = 32'h1234_5678;
        csr_we     = 1'b1;
        #1;
        chk("tid1_rbw", {32'd0, csr_rvalue}, 64'h3);
        tick();
        csr_we = 1'b0;
        rd_chk("tid1_masked", 14'h47, 32'h0000_5678);

        // One-shot, INITVAL=4: 16 down to 0, single pending
        csr_wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0011);
        rd_chk("tcfg0_rd", 14'h41, 32'h0000_0011);
        for (int k = 16; k >= 0; k--) begin
            rd_chk($sformatf("os_tval_%0d", k), 14'h42, 32'(k));
            chk($sformatf("os_irq_%0d", k), {63'd0, irq_pending[0]}, 64'd0);
            tick();
        end
        chk("os_irq_set", {63'd0, irq_pending[0]}, 64'd1);
        chk("os_int", {63'd0, timer_int}, 64'd1);
        rd_chk("os_tval_exp", 14'h42, 32'hFFFF_FFFF);
        csr_wr(14'h44, 32'hFFFF_FFFF, 32'h1);
        chk("os_irq_clr", {63'd0, irq_pending[0]}, 64'd0);
        for (int k = 0; k < 10; k++) tick();
        chk("os_no_reset", {63'd0, irq_pending[0]}, 64'd0);
        rd_chk("os_tval_hold", 14'h42, 32'hFFFF_FFFF);

        // Periodic, INITVAL=2 on channel 1
        csr_wr(14'h45, 32'hFFFF_FFFF, 32'h0000_000B);
        rd_chk("per_tval_8", 14'h46, 32'd8);
        for (int k = 0; k < 8; k++) tick();
        rd_chk("per_tval_0", 14'h46, 32'd0);
        chk("per_irq_0", {63'd0, irq_pending[1]}, 64'd0);
        tick();
        chk("per_irq_set", {63'd0, irq_pending[1]}, 64'd1);
        rd_chk("per_reload", 14'h46, 32'd8);
        csr_wr(14'h48, 32'hFFFF_FFFF, 32'h1);
        chk("per_irq_clr", {63'd0, irq_pending[1]}, 64'd0);
        rd_chk("per_tval_7", 14'h46, 32'd7);
        for (int k = 0; k < 7; k++) tick();
        rd_chk("per_tval_0b", 14'h46, 32'd0);
        chk("per_irq_0b", {63'd0, irq_pending[1]}, 64'd0);

        // Clear in the expiry cycle: set wins; mask=0 clear ignored
        csr_wr(14'h48, 32'hFFFF_FFFF, 32'h1);
        chk("setwins_irq", {63'd0, irq_pending[1]}, 64'd1);
        rd_chk("setwins_tval", 14'h46, 32'd8);
        csr_wr(14'h48, 32'h0, 32'h1);
        chk("mask0_irq", {63'd0, irq_pending[1]}, 64'd1);
        rd_chk("mask0_tval", 14'h46, 32'd7);

        // Freeze with EN=0 at 5, then restart with INITVAL=1
        csr_wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000D);
        rd_chk("frz_tval_12", 14'h42, 32'd12);
        for (int k = 0; k < 7; k++) tick();
        rd_chk("frz_tval_5", 14'h42, 32'd5);
        csr_wr(14'h41, 32'h0000_0001, 32'h0);
        for (int k = 0; k < 20; k++) begin
            rd_chk($sformatf("frz_hold_%0d", k), 14'h42, 32'd5);
            tick();
        end
        chk("frz_irq", {63'd0, irq_pending[0]}, 64'd0);
        rd_chk("frz_tcfg", 14'h41, 32'h0000_000C);
        csr_wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0005);
        rd_chk("restart_tval", 14'h42, 32'd4);

        // INITVAL=0 periodic: pending every cycle, clear ineffective; then reset
        csr_wr(14'h43, 32'hFFFF_FFFF, 32'h0000_DEAD);
        rd_chk("tid0_wr", 14'h43, 32'h0000_DEAD);
        csr_wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0003);
        rd_chk("iv0_tval", 14'h42, 32'd0);
        tick();
        chk("iv0_irq", {63'd0, irq_pending[0]}, 64'd1);
        csr_wr(14'h44, 32'hFFFF_FFFF, 32'h1);
        chk("iv0_clr_ineff", {63'd0, irq_pending[0]}, 64'd1);
        reset = 1'b1;
        tick();
        chk("rst2_irq", {62'd0, irq_pending}, 64'd0);
        chk("rst2_int", {63'd0, timer_int}, 64'd0);
        chk("rst2_stable", stable_cnt, 64'd0);
        rd_chk("rst2_tcfg0", 14'h41, 32'h0);
        rd_chk("rst2_tval0", 14'h42, 32'hFFFF_FFFF);
        rd_chk("rst2_tid0", 14'h43, 32'h0000_0003);
        rd_chk("rst2_tval1", 14'h46, 32'hFFFF_FFFF);
        rd_chk("rst2_tid1", 14'h47, 32'h0000_0003);
        reset = 1'b0;
        tick();
        chk("rst2_stable_1", stable_cnt, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
